// File: rtl/playfield_pixel_pipe.sv
// playfield_pixel_pipe: per-pixel bg/spike ROM fetch and composite.
// Three-register pipe (addr, rom, out) plus per-frame scroll counter.
module playfield_pixel_pipe #(
  parameter int       NUM_SPIKES      = 4,
  parameter int       SPIKE_W         = 32,
  parameter int       BG_W            = 160,
  parameter int       BG_H            = 120,
  parameter int       BG_SHIFT        = 2,
  parameter int       SCROLL_STEP     = 2,
  parameter bit [2:0] TRANSPARENT_IDX = 3'd0
) (
  input  logic                    vga_clk,
  input  logic                    reset_n,
  input  logic [9:0]              DrawX,
  input  logic [9:0]              DrawY,
  input  logic                    blank_in,
  input  logic                    hs_in,
  input  logic                    vs_in,
  input  logic [1:0]              game_state,
  input  logic [10*NUM_SPIKES-1:0] spike_x,
  input  logic [10*NUM_SPIKES-1:0] spike_y,
  input  logic [NUM_SPIKES-1:0]   spike_en,
  output logic [14:0]             bg_rom_addr,
  input  logic [3:0]              bg_rom_data,
  output logic [9:0]              spike_rom_addr,
  input  logic [2:0]              spike_rom_data,
  output logic                    pix_layer,
  output logic [3:0]              pix_bg_idx,
  output logic [2:0]              pix_spike_idx,
  output logic                    pix_valid,
  output logic                    hs_out,
  output logic                    vs_out,
  output logic [9:0]              scroll
);

  localparam int          BG_PIX = BG_W << BG_SHIFT;
  localparam logic [10:0] W_PIX  = 11'(BG_PIX);
  localparam logic [10:0] W_SPK  = 11'(SPIKE_W);
  localparam logic [10:0] W_STEP = 11'(SCROLL_STEP);

  logic [9:0]  r_scroll;
  logic        r_vs_q;
  logic [14:0] r_bg_addr;
  logic [9:0]  r_sp_addr;
  logic        r_hit_a, r_blank_a, r_hs_a, r_vs_a;
  logic        r_hit_b, r_blank_b, r_hs_b, r_vs_b;
  logic        r_layer, r_valid, r_hs_o, r_vs_o;
  logic [3:0]  r_bg_idx;
  logic [2:0]  r_sp_idx;

  logic        w_play;
  logic        w_frame;
  logic [10:0] w_scroll_nx;
  logic [10:0] w_xs_sum, w_xs;
  logic [14:0] w_bg_addr;
  logic [10:0] w_px, w_py, w_sx, w_sy, w_dx, w_dy;
  logic        w_hit;
  logic [9:0]  w_sp_addr;

  assign w_play  = (game_state == 2'd1) || (game_state == 2'd3);
  assign w_frame = r_vs_q && !vs_in;

  assign w_scroll_nx = {1'b0, r_scroll} + W_STEP;

  assign w_xs_sum  = {1'b0, DrawX} + {1'b0, r_scroll};
  assign w_xs      = (w_xs_sum >= W_PIX) ? w_xs_sum - W_PIX : w_xs_sum;
  assign w_bg_addr = 15'(32'(DrawY >> BG_SHIFT) * BG_W)
                   + 15'(w_xs >> BG_SHIFT);

  assign w_px = {1'b0, DrawX};
  assign w_py = {1'b0, DrawY};

  // Spike hit test; walk high to low so the lowest slot wins.
  always_comb begin
    w_hit     = 1'b0;
    w_sp_addr = '0;
    w_sx      = '0;
    w_sy      = '0;
    w_dx      = '0;
    w_dy      = '0;
    for (int i = NUM_SPIKES - 1; i >= 0; i--) begin
      w_sx = {1'b0, spike_x[10*i +: 10]};
      w_sy = {1'b0, spike_y[10*i +: 10]};
      w_dx = w_px - w_sx;
      w_dy = w_py - w_sy;
      if (spike_en[i] &&
          w_px >= w_sx && w_px < w_sx + W_SPK &&
          w_py >= w_sy && w_py < w_sy + W_SPK) begin
        w_hit     = 1'b1;
        w_sp_addr = 10'(w_dy * W_SPK + w_dx);
      end
    end
  end

  // Scroll advances only on a vsync falling edge.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vs_q   <= 1'b1;
      r_scroll <= '0;
    end else begin
      r_vs_q <= vs_in;
      if (w_frame) begin
        unique case (game_state)
          2'd1: r_scroll <= (w_scroll_nx >= W_PIX)
                          ? 10'(w_scroll_nx - W_PIX)
                          : w_scroll_nx[9:0];
          2'd0: r_scroll <= '0;
          default: r_scroll <= r_scroll;
        endcase
      end
    end
  end

  // Stage A: ROM addresses plus the control that rides with the pixel.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bg_addr <= '0;
      r_sp_addr <= '0;
      r_hit_a   <= 1'b0;
      r_blank_a <= 1'b0;
      r_hs_a    <= 1'b1;
      r_vs_a    <= 1'b1;
    end else begin
      r_bg_addr <= blank_in ? w_bg_addr : '0;
      r_sp_addr <= (blank_in && w_play && w_hit) ? w_sp_addr : '0;
      r_hit_a   <= blank_in && w_play && w_hit;
      r_blank_a <= blank_in;
      r_hs_a    <= hs_in;
      r_vs_a    <= vs_in;
    end
  end

  // Stage B: wait one cycle alongside the synchronous ROMs.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hit_b   <= 1'b0;
      r_blank_b <= 1'b0;
      r_hs_b    <= 1'b1;
      r_vs_b    <= 1'b1;
    end else begin
      r_hit_b   <= r_hit_a;
      r_blank_b <= r_blank_a;
      r_hs_b    <= r_hs_a;
      r_vs_b    <= r_vs_a;
    end
  end

  // Stage C: transparency/priority and blanking of the palette indices.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_layer  <= 1'b0;
      r_bg_idx <= '0;
      r_sp_idx <= '0;
      r_valid  <= 1'b0;
      r_hs_o   <= 1'b1;
      r_vs_o   <= 1'b1;
    end else begin
      r_valid <= r_blank_b;
      r_hs_o  <= r_hs_b;
      r_vs_o  <= r_vs_b;
      if (r_blank_b) begin
        r_layer  <= r_hit_b && (spike_rom_data != TRANSPARENT_IDX);
        r_bg_idx <= bg_rom_data;
        r_sp_idx <= spike_rom_data;
      end else begin
        r_layer  <= 1'b0;
        r_bg_idx <= '0;
        r_sp_idx <= '0;
      end
    end
  end

  assign bg_rom_addr    = r_bg_addr;
  assign spike_rom_addr = r_sp_addr;
  assign pix_layer      = r_layer;
  assign pix_bg_idx     = r_bg_idx;
  assign pix_spike_idx  = r_sp_idx;
  assign pix_valid      = r_valid;
  assign hs_out         = r_hs_o;
  assign vs_out         = r_vs_o;
  assign scroll         = r_scroll;

endmodule

// File: doc/playfield_pixel_pipe.md
# playfield_pixel_pipe

Per-pixel fetch and composite pipeline that sits directly upstream of the spike and background palette lookups. For each VGA raster coordinate it does three things: computes the background and spike sprite ROM addresses, including horizontal background scroll; reads back the ROM indices; and applies spike transparency and priority. It emits a layer select plus palette indices and sync signals, all aligned to a fixed latency, and it owns the per-frame background scroll counter.

## Interface
Parameters:
- NUM_SPIKES, 4, number of spike sprite slots
- SPIKE_W, 32, spike sprite width/height in pixels (square)
- BG_W, 160, background ROM width in texels
- BG_H, 120, background ROM height in texels
- BG_SHIFT, 2, texel = 2^BG_SHIFT screen pixels per axis
- SCROLL_STEP, 2, screen pixels advanced per frame while playing
- TRANSPARENT_IDX, 3'd0, spike palette index treated as see-through

Ports (clock and reset first):
- vga_clk  in  1  pixel clock
- reset_n  in  1  asynchronous active-low reset
- DrawX  in  10  raster column
- DrawY  in  10  raster row
- blank_in  in  1  1 = active video
- hs_in  in  1  hsync, active-low
- vs_in  in  1  vsync, active-low
- game_state  in  2  0 menu, 1 play, 2 finish, 3 pause
- spike_x  in  10*NUM_SPIKES  spike left edges, slot i at [10i+9:10i]
- spike_y  in  10*NUM_SPIKES  spike top edges
- spike_en  in  NUM_SPIKES  slot enable
- bg_rom_addr  out  15  registered background ROM address
- bg_rom_data  in  4  background index, valid 1 cycle after address
- spike_rom_addr  out  10  registered spike ROM address
- spike_rom_data  in  3  spike index, valid 1 cycle after address
- pix_layer  out  1  0 background, 1 spike
- pix_bg_idx  out  4  background palette index
- pix_spike_idx  out  3  spike palette index
- pix_valid  out  1  active video at output
- hs_out  out  1  delayed hsync
- vs_out  out  1  delayed vsync
- scroll  out  10  current scroll offset in screen pixels

## Operation
- Stage A (address register):
  - xs = DrawX + scroll; if xs ≥ BG_W<<BG_SHIFT (640), subtract 640.
  - bg_rom_addr = (DrawY>>BG_SHIFT)*BG_W + (xs>>BG_SHIFT).
  - When blank_in = 0, bg_rom_addr = 0 and spike_rom_addr = 0.
- Spike hit test for slot i:
  - Hit when spike_en[i], spike_x ≤ DrawX < spike_x+SPIKE_W, and spike_y ≤ DrawY < spike_y+SPIKE_W.
  - Compare at 11 bits so no overflow near 639/479.
  - If several slots hit, the lowest index wins.
  - spike_rom_addr = (DrawY−sy)*SPIKE_W + (DrawX−sx) for the winner; 0 if no hit.
  - Registered hit flag travels with the pixel.
  - Hits are suppressed unless game_state ∈ {play, pause}.
- Stage B: external synchronous ROMs return data. Hit, blank and syncs are delayed one more register.
- Stage C (output register):
  - pix_layer = hit && spike_rom_data ≠ TRANSPARENT_IDX.
  - pix_bg_idx = bg_rom_data and pix_spike_idx = spike_rom_data, unconditionally.
  - When not valid: pix_layer = 0 and both indices = 0.
- Scroll counter:
  - vs_in is registered; a frame event is a 1→0 transition.
  - On a frame event:
    - play: scroll += SCROLL_STEP, modulo 640.
    - menu: scroll = 0.
    - finish/pause: hold.
  - scroll changes only at frame events, so it is constant across any active frame.
  - game_state changes between events take effect at the next event, except menu, which also zeroes scroll at that event only.

## Timing
- Fixed latency 3 cycles: inputs sampled at edge k appear on pix_*/hs_out/vs_out after edge k+2.
- ROM addresses are registered outputs after edge k.
- One pixel per clock, no stalls, no handshake.
- Reset (async assert, sync-released by the external reset synchronizer) sets:
  - all pipeline registers and scroll to 0
  - hs_out = vs_out = 1
  - pix_valid = pix_layer = 0, indices = 0
  - bg_rom_addr = spike_rom_addr = 0
- Reset mid-frame takes effect immediately. The pipeline refills after release; the first 2 output cycles after release show reset values.
- Scroll wrap: scroll = 638 with step 2 → 0. Values never reach ≥ 640.
- Spike at spike_x = 630 clips at the screen edge, with no address wrap into a neighbouring row.

## Test plan
- Reset, then release. Required: hs_out = vs_out = 1, pix_valid = 0, scroll = 0. Drive blank_in = 1, DrawX = 5, DrawY = 8. Required: bg_rom_addr = 2*160+1 = 321 after 1 edge, pix_valid = 1 after 3 edges.
- Spike slot 0 at (100,200), ROM model returns 3'd5 at addr 0. Pixel (100,200): spike_rom_addr = 0, pix_layer = 1, pix_spike_idx = 5. Same pixel with ROM returning 0: pix_layer = 0.
- Slots 0 and 2 both cover (300,300), slot 0 at (290,290) and slot 2 at (300,300). Required: spike_rom_addr = 10*32+10 = 330 (slot 0 wins).
- game_state = play with 320 vsync falling edges. Required: scroll = 0. With one edge, scroll = 2; then DrawX = 638 gives xs = 0 and bg_rom_addr column 0.
- Play to scroll = 40, then finish with 5 frames: scroll stays 40. Then menu with 1 frame: scroll = 0.
- Assert reset_n = 0 mid-line. Required: outputs clear within the same cycle; after release the first valid pixel appears exactly 3 cycles after valid inputs resume.
